flood_fill: RTL and testbench

Iterative flood-fill engine that sits directly upstream of the tile-state register bank. When the player reveals a zero-count tile, it expands the connected zero region plus its numbered border one ring per clock. It then presents the result as a tile mask on `flood_update` with a one-cycle `flood_apply` pulse. The mask, board masks and tile indexing are shared with tile state: index = row*GRID_SIZE + col.

---
 rtl/minesweeper_pkg.sv | 38 +++
 rtl/flood_neighbors.sv | 57 +++++
 rtl/flood_fill.sv | 141 ++++++++++++++
 tb/tb_flood_fill.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minesweeper_pkg
// Description : Shared board constants for the tile-state datapath: default
//               grid geometry, flood-fill state encoding and the first/last
//               column masks of the default board.
//               Tile indexing everywhere is index = row*GRID_SIZE + col.
// Revision    : 1.0 - initial release
// ============================================================================
package minesweeper_pkg;

    localparam int c_grid_size   = 8;
    localparam int c_total_tiles = c_grid_size * c_grid_size;
    localparam int c_index_bits  = $clog2(c_total_tiles);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } flood_state_t;

    // Mask with a 1 in every tile of column `col` on the default board.
    function automatic logic [c_total_tiles-1:0] col_mask(input int col);
        logic [c_total_tiles-1:0] m;
        m = '0;
        for (int i = 0; i < c_total_tiles; i++) begin
            if ((i % c_grid_size) == col) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [c_total_tiles-1:0] c_first_col_mask = col_mask(0);
    localparam logic [c_total_tiles-1:0] c_last_col_mask  = col_mask(c_grid_size - 1);

endpackage
`default_nettype wire

// File: rtl/flood_neighbors.sv
`default_nettype none
// ============================================================================
// Module      : flood_neighbors
// Description : Combinational spread of a tile mask to its neighbours.
//               Every set tile lights the tiles adjacent to it (not itself).
//               Horizontal terms are edge-masked so nothing wraps from the
//               last column of one row into the first column of the next;
//               vertical shifts simply fall off the top/bottom of the vector.
// Config      : FLOOD_DIAG_EN defined   -> 8-connectivity (adds diagonals)
//               FLOOD_DIAG_EN undefined -> 4-connectivity (orthogonal only)
// Ports       : mask_in    - tiles to spread from
//               spread_out - union of all neighbours of mask_in
// Revision    : 1.0 - initial release
// ============================================================================
module flood_neighbors #(
    parameter int GRID_SIZE   = 8,
    parameter int TOTAL_TILES = GRID_SIZE * GRID_SIZE
) (
    input  logic [TOTAL_TILES-1:0] mask_in,
    output logic [TOTAL_TILES-1:0] spread_out
);

    logic [TOTAL_TILES-1:0] w_first_col;
    logic [TOTAL_TILES-1:0] w_last_col;
    logic [TOTAL_TILES-1:0] w_not_first;
    logic [TOTAL_TILES-1:0] w_not_last;
    logic [TOTAL_TILES-1:0] w_ortho;
    logic [TOTAL_TILES-1:0] w_diag;

    for (genvar gi = 0; gi < TOTAL_TILES; gi++) begin : g_col_mask
        assign w_first_col[gi] = ((gi % GRID_SIZE) == 0);
        assign w_last_col[gi]  = ((gi % GRID_SIZE) == (GRID_SIZE - 1));
    end

    // Sources that may move right (+col) must not sit in the last column,
    // sources that may move left (-col) must not sit in the first column.
    assign w_not_last  = mask_in & ~w_last_col;
    assign w_not_first = mask_in & ~w_first_col;

    assign w_ortho = (w_not_last  << 1)
                   | (w_not_first >> 1)
                   | (mask_in     << GRID_SIZE)
                   | (mask_in     >> GRID_SIZE);

`ifdef FLOOD_DIAG_EN
    assign w_diag = (w_not_last  << (GRID_SIZE + 1))   // down-right
                  | (w_not_first << (GRID_SIZE - 1))   // down-left
                  | (w_not_last  >> (GRID_SIZE - 1))   // up-right
                  | (w_not_first >> (GRID_SIZE + 1));  // up-left
`else
    assign w_diag = '0;
`endif

    assign spread_out = w_ortho | w_diag;

endmodule
`default_nettype wire

// File: rtl/flood_fill.sv
`default_nettype none
// ============================================================================
// Module      : flood_fill
// Description : Iterative flood-fill engine feeding the tile-state bank.
//               From an accepted seed it grows the connected zero region plus
//               its numbered border one ring per clock, then strobes the
//               visited mask out with a single-cycle flood_apply.
// Config      : FLOOD_DIAG_EN selects 8-connectivity (see flood_neighbors).
// Ports       : clk, rst (async, active-low)
//               start/start_index - fill request and seed tile
//               clear             - synchronous abort, wins over start
//               zero_mask, mine_mask, flagged, revealed - live board masks
//               busy              - engine not idle
//               flood_update      - visited mask, held until start/clear/rst
//               flood_apply       - one-cycle strobe, flood_update valid
// Revision    : 1.0 - initial release
// ============================================================================
module flood_fill
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE   = c_grid_size,
    parameter int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
    parameter int INDEX_BITS  = $clog2(TOTAL_TILES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INDEX_BITS-1:0]  start_index,
    input  logic                   clear,
    input  logic [TOTAL_TILES-1:0] zero_mask,
    input  logic [TOTAL_TILES-1:0] mine_mask,
    input  logic [TOTAL_TILES-1:0] flagged,
    input  logic [TOTAL_TILES-1:0] revealed,
    output logic                   busy,
    output logic [TOTAL_TILES-1:0] flood_update,
    output logic                   flood_apply
);

    localparam logic [INDEX_BITS-1:0] c_count_max = INDEX_BITS'(TOTAL_TILES - 1);

    flood_state_t           r_state;
    flood_state_t           w_state_next;
    logic [TOTAL_TILES-1:0] r_visited;
    logic [TOTAL_TILES-1:0] w_visited_next;
    logic [TOTAL_TILES-1:0] r_frontier;
    logic [TOTAL_TILES-1:0] w_frontier_next;
    logic [INDEX_BITS-1:0]  r_count;
    logic [INDEX_BITS-1:0]  w_count_next;
    logic                   r_busy;
    logic                   r_apply;

    logic [TOTAL_TILES-1:0] w_spread;
    logic [TOTAL_TILES-1:0] w_new;
    logic [TOTAL_TILES-1:0] w_seed_onehot;
    logic                   w_seed_ok;

    // Only zero tiles on the frontier propagate; numbered border tiles get
    // revealed but stop the expansion.
    flood_neighbors #(
        .GRID_SIZE   (GRID_SIZE),
        .TOTAL_TILES (TOTAL_TILES)
    ) u_neighbors (
        .mask_in    (r_frontier & zero_mask),
        .spread_out (w_spread)
    );

    assign w_new = w_spread & ~r_visited & ~flagged & ~mine_mask & ~revealed;

    assign w_seed_onehot = TOTAL_TILES'(1) << start_index;
    assign w_seed_ok     = zero_mask[start_index] & ~flagged[start_index]
                         & ~mine_mask[start_index] & ~revealed[start_index];

    always_comb begin
        w_state_next    = r_state;
        w_visited_next  = r_visited;
        w_frontier_next = r_frontier;
        w_count_next    = r_count;

        case (r_state)
            IDLE: begin
                if (start && w_seed_ok) begin
                    w_visited_next  = w_seed_onehot;
                    w_frontier_next = w_seed_onehot;
                    w_count_next    = '0;
                    w_state_next    = EXPAND;
                end
            end
            EXPAND: begin
                w_visited_next  = r_visited | w_new;
                w_frontier_next = w_new;
                if (r_count != c_count_max) begin
                    w_count_next = r_count + 1'b1;
                end
                // The count bound only guards against a pathological board;
                // a real region always runs dry first.
                if ((w_new == '0) || (w_count_next == c_count_max)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (clear) begin
            w_state_next    = IDLE;
            w_visited_next  = '0;
            w_frontier_next = '0;
            w_count_next    = '0;
        end
    end

    // busy/flood_apply are registered from the next state so they line up
    // with the state register without any input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_visited  <= '0;
            r_frontier <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_apply    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_visited  <= w_visited_next;
            r_frontier <= w_frontier_next;
            r_count    <= w_count_next;
            r_busy     <= (w_state_next != IDLE);
            r_apply    <= (w_state_next == DONE);
        end
    end

    assign busy         = r_busy;
    assign flood_update = r_visited;
    assign flood_apply  = r_apply;

endmodule
`default_nettype wire

// File: tb/tb_flood_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_flood_fill
// Description : Self-checking bench for flood_fill on the default 8x8 board.
//               Stimulus pushes the expected mask and strobe edge into a
//               scoreboard; a monitor pops on every flood_apply.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flood_fill;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  start_index;
    logic        clear;
    logic [63:0] zero_mask;
    logic [63:0] mine_mask;
    logic [63:0] flagged;
    logic [63:0] revealed;
    logic        busy;
    logic [63:0] flood_update;
    logic        flood_apply;

    typedef struct {
        logic [63:0] mask;
        int          edge_no;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    localparam logic [63:0] c_all = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef FLOOD_DIAG_EN
    localparam int          c_depth_all = 7;
    localparam logic [63:0] c_m27       = 64'h0000_001C_1C1C_0000;
    localparam logic [63:0] c_m7        = 64'h0000_0000_0000_C0C0;
`else
    localparam int          c_depth_all = 14;
    localparam logic [63:0] c_m27       = 64'h0000_0008_1C08_0000;
    localparam logic [63:0] c_m7        = 64'h0000_0000_0000_80C0;
`endif
    localparam logic [63:0] c_no9 = 64'hFFFF_FFFF_FFFF_FDFF;

    flood_fill dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_index  (start_index),
        .clear        (clear),
        .zero_mask    (zero_mask),
        .mine_mask    (mine_mask),
        .flagged      (flagged),
        .revealed     (revealed),
        .busy         (busy),
        .flood_update (flood_update),
        .flood_apply  (flood_apply)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && flood_apply) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_apply: got strobe at edge %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("apply_mask", flood_update, e.mask);
                check("apply_busy", {63'd0, busy}, 64'd1);
                if (e.edge_no >= 0) begin
                    check("apply_edge", 64'(cyc), 64'(e.edge_no));
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == 100) check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    // Issue an accepted fill; depth < 0 means strobe timing is not checked.
    task automatic do_fill(input int idx, input logic [63:0] exp_mask, input int depth);
        exp_t e;
        e.mask    = exp_mask;
        e.edge_no = (depth < 0) ? -1 : (cyc + depth + 2);
        sb_q.push_back(e);
        start       = 1'b1;
        start_index = 6'(idx);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic try_ignored(input int idx, input logic [63:0] hold_mask, input string nm);
        start       = 1'b1;
        start_index = 6'(idx);
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        check({nm, "_busy2"}, {63'd0, busy}, 64'd0);
        check({nm, "_hold"}, flood_update, hold_mask);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start_index = '0; clear = 1'b0;
        zero_mask = '0; mine_mask = '0; flagged = '0; revealed = '0;
        #2;
        check("rst_busy",   {63'd0, busy},        64'd0);
        check("rst_update", flood_update,          64'd0);
        check("rst_apply",  {63'd0, flood_apply}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Open board from the corner.
        zero_mask = c_all;
        do_fill(0, c_all, c_depth_all);
        repeat (2) @(negedge clk);
        check("hold_all", flood_update, c_all);

        // Single zero tile in the middle.
        zero_mask = 64'd1 << 27;
        do_fill(27, c_m27, 1);

        // Single zero tile at the end of row 0: bit 8 must not light.
        zero_mask = 64'd1 << 7;
        do_fill(7, c_m7, 1);
        check("no_wrap_bit8", {63'd0, flood_update[8]}, 64'd0);

        // Flag blocks one tile; flagged seed is refused.
        zero_mask = c_all;
        flagged   = 64'd1 << 9;
        do_fill(0, c_no9, -1);
        try_ignored(9, c_no9, "flag_seed");
        flagged = '0;

        // Revealed and mine seeds are refused.
        revealed = 64'd1 << 27;
        try_ignored(27, c_no9, "revealed_seed");
        revealed  = '0;
        mine_mask = 64'd1 << 5;
        try_ignored(5, c_no9, "mine_seed");
        mine_mask = '0;

        // Second start while busy is ignored.
        zero_mask = (64'd1 << 27) | 64'd1;
        begin
            exp_t e;
            e.mask    = c_m27;
            e.edge_no = cyc + 3;
            sb_q.push_back(e);
        end
        start = 1'b1; start_index = 6'd27;
        @(negedge clk);
        start_index = 6'd0;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("busy_start_hold", flood_update, c_m27);

        // Clear during EXPAND: no strobe, mask cleared.
        zero_mask = c_all;
        start = 1'b1; start_index = 6'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_clear_busy", {63'd0, busy}, 64'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_busy",   {63'd0, busy}, 64'd0);
        check("clear_update", flood_update,  64'd0);
        repeat (20) @(negedge clk);
        check("clear_stays_idle", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-fill.
        start = 1'b1; start_index = 6'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy",   {63'd0, busy},        64'd0);
        check("arst_update", flood_update,          64'd0);
        check("arst_apply",  {63'd0, flood_apply}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_stays_idle", {63'd0, busy}, 64'd0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
